// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the divided-clock bank.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        FILTER,
        RUN
    } bank_state_t;

    localparam int DEFAULT_CNT_WIDTH = 16;
    localparam int MIN_DIV = 2;

    typedef logic [DEFAULT_CNT_WIDTH-1:0] div_ratio_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending ratio and registered outputs.
module clk_div_channel
    import clk_gen_pkg::*;
#(
    parameter int W           = DEFAULT_CNT_WIDTH,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         hold,
    input  logic         restart,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         clk_out,
    output logic         clk_en
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] pval_q, pval_d;
    logic         pend_q, pend_d;
    logic         out_d, en_d;
    logic         stopped, last, div_ok;

    assign stopped = div_q < W'(MIN_DIV);
    assign last    = cnt_q == div_q - W'(1);

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        pval_d = load ? load_val : pval_q;
        pend_d = pend_q | load;
        if (!run) begin
            cnt_d = '0;
            if (pend_q) begin
                div_d  = pval_q;
                pend_d = load;
            end
        end else if (restart) begin
            cnt_d = '0;
            // a same-cycle load bypasses the pending register
            if (load) begin
                div_d  = load_val;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = pval_q;
                pend_d = 1'b0;
            end
        end else if (hold || stopped || last) begin
            cnt_d = '0;
            if (pend_q) begin
                div_d  = pval_q;
                pend_d = load;
            end
        end else begin
            cnt_d = cnt_q + W'(1);
        end
        div_ok = div_d >= W'(MIN_DIV);
        out_d  = run && div_ok && (cnt_d < (div_d >> 1));
        en_d   = run && div_ok && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            div_q   <= W'(DEFAULT_DIV);
            pval_q  <= W'(DEFAULT_DIV);
            pend_q  <= 1'b0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pval_q  <= pval_d;
            pend_q  <= pend_d;
            clk_out <= out_d;
            clk_en  <= en_d;
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Lock-filtered bank of phase-aligned clock dividers driven from the PLL clock.
module clock_divider_bank
    import clk_gen_pkg::*;
#(
    parameter int NUM_CLOCKS  = 3,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int DEFAULT_DIV = 4,
    parameter int LOCK_FILTER = 8
) (
    input  logic                            refclk,
    input  logic                            rst,
    input  logic                            pll_locked,
    input  logic [NUM_CLOCKS*CNT_WIDTH-1:0] div_value,
    input  logic                            div_load,
    input  logic                            sync_restart,
    output logic [NUM_CLOCKS-1:0]           clk_out,
    output logic [NUM_CLOCKS-1:0]           clk_en,
    output logic                            locked
);

    localparam int FW = $clog2(LOCK_FILTER + 1);

    bank_state_t   state_q, state_d;
    logic [FW-1:0] filt_q, filt_d;
    logic          sync1, lk_s;
    logic          run_next, hold, restart;

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        unique case (state_q)
            UNLOCKED: begin
                if (lk_s) begin
                    state_d = FILTER;
                    filt_d  = FW'(1);
                end
            end
            FILTER: begin
                if (!lk_s) begin
                    state_d = UNLOCKED;
                    filt_d  = '0;
                end else if (filt_q == FW'(LOCK_FILTER)) begin
                    state_d = RUN;
                end else begin
                    filt_d = filt_q + FW'(1);
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d = UNLOCKED;
                    filt_d  = '0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                filt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            lk_s    <= 1'b0;
            state_q <= UNLOCKED;
            filt_q  <= '0;
            locked  <= 1'b0;
        end else begin
            sync1   <= pll_locked;
            lk_s    <= sync1;
            state_q <= state_d;
            filt_q  <= filt_d;
            locked  <= state_d == RUN;
        end
    end

    // channels follow the next state so outputs drop on the edge locked falls
    assign run_next = state_d == RUN;
    assign hold     = state_q != RUN;
    assign restart  = sync_restart && (state_q == RUN);

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
        clk_div_channel #(
            .W           (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (refclk),
            .rst      (rst),
            .run      (run_next),
            .hold     (hold),
            .restart  (restart),
            .load     (div_load),
            .load_val (div_value[i*CNT_WIDTH +: CNT_WIDTH]),
            .clk_out  (clk_out[i]),
            .clk_en   (clk_en[i])
        );
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parametrised successor to the single-output PLL clock wrapper in the codec configuration path.
- Takes the PLL output clock plus its raw lock flag and derives NUM_CLOCKS phase-aligned divided clocks and matching one-cycle clock enables for codec MCLK/BCLK/LRCLK and the I2C configuration logic.
- Adds what the PLL wrapper lacks: run-time reprogrammable ratios, lock filtering, lock-gated start/stop and explicit phase realignment.

Parameters:
- NUM_CLOCKS, 3, number of divider channels (1..8).
- CNT_WIDTH, 16, width of each divide ratio and channel counter.
- DEFAULT_DIV, 4, ratio loaded into every channel at reset.
- LOCK_FILTER, 8, consecutive synchronised-high cycles of pll_locked required before the outputs run.

Ports:
- refclk  in  1  Sole clock (PLL output); all logic on its rising edge.
- rst  in  1  Synchronous, active-low reset.
- pll_locked  in  1  Raw PLL lock flag, asynchronous to refclk.
- div_value  in  NUM_CLOCKS*CNT_WIDTH  Packed new ratios; channel i at [i*CNT_WIDTH +: CNT_WIDTH].
- div_load  in  1  One-cycle strobe; captures div_value.
- sync_restart  in  1  One-cycle strobe; realigns all channel counters.
- clk_out  out  NUM_CLOCKS  Registered divided clocks.
- clk_en  out  NUM_CLOCKS  One-cycle enables, high on the first high cycle of each clk_out period.
- locked  out  1  Filtered lock; outputs are running.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to UNLOCKED; sync flops, filter counter and channel counters clear to 0.
  - Active ratio and pending ratio go to DEFAULT_DIV; pending flags clear.
  - clk_out=0, clk_en=0, locked=0.
  - Reset asserted mid-operation behaves identically.
- Lock synchroniser: two-flop synchroniser on pll_locked gives lk_s.
- Bank FSM (UNLOCKED / FILTER / RUN):
  - UNLOCKED: lk_s=1 -> FILTER, with the filter counter set to 1.
  - FILTER: lk_s=1 increments the filter counter; when the count equals LOCK_FILTER -> RUN. lk_s=0 -> UNLOCKED.
  - RUN: lk_s=0 -> UNLOCKED.
  - locked is a register, 1 only in RUN.
  - Timing: if pll_locked is first sampled high at edge k, locked=1 from edge k+LOCK_FILTER+2. If it is first sampled low at edge k, locked=0 from edge k+2.
- Outside RUN:
  - All channel counters are held at 0; clk_out=0, clk_en=0.
  - Entering RUN starts every channel at cnt=0 on the same cycle, so channels are phase-aligned.
- Channel i, active ratio D:
  - D<2: channel stopped; cnt=0, clk_out=0, clk_en=0.
  - D>=2: cnt counts 0..D-1 and wraps to 0.
  - clk_out = (cnt < D>>1), registered alongside cnt. The output is high for floor(D/2) cycles and low for ceil(D/2) cycles.
  - clk_en = (cnt==0).
- Ratio reload:
  - div_load captures all channels' div_value into pending registers and sets each channel's pending flag.
  - A running channel applies its pending ratio on the cycle its cnt wraps to 0, so no short or long pulse occurs.
  - A stopped channel, or any channel outside RUN, applies the pending ratio on the next cycle.
  - div_load arriving while a ratio is pending overwrites the pending value.
- sync_restart:
  - In RUN, every channel's cnt becomes 0 on the next edge, and any pending ratio is applied on that edge.
  - Ignored outside RUN.
  - If div_load and sync_restart occur in the same cycle, the new div_value takes effect immediately on the restart edge.
- Simultaneous events:
  - A lk_s drop in RUN overrides everything; outputs are 0 the cycle locked falls.
  - A ratio of all-ones is legal; the counter never exceeds D-1.

Decomposition:
- Package clk_gen_pkg holds:
  - the bank state enum (UNLOCKED, FILTER, RUN);
  - CNT_WIDTH default;
  - a div_ratio_t typedef;
  - the MIN_DIV=2 constant.
- Sub-module clk_div_channel: one counter, active/pending ratio, clk_out/clk_en logic. Instantiated NUM_CLOCKS times by generate.
- The top level holds the synchroniser, lock filter FSM and strobe fan-out.

Test Plan:
- Lock filter: LOCK_FILTER=8, pll_locked high from edge 0 after reset -> locked=0 through edge 9, 1 at edge 10; all channels show clk_en=1 together on the first RUN cycle.
- Even ratio: ch0 D=4 -> clk_out repeats 1,1,0,0; clk_en pulses every 4 cycles on the first '1'.
- Odd and stopped ratios: ch1 D=5 -> clk_out 1,1,0,0,0. ch2 D=1 or D=0 -> clk_out and clk_en constantly 0.
- Glitch-free reload: ch0 D=4 running, div_load with 8 at cnt=1 -> pattern finishes 1,0,0 then 1,1,1,1,0,0,0,0; no other period lengths.
- Lock loss: pll_locked low for 1 cycle in RUN -> locked low 2 edges later; outputs 0; relock needs another 8 filtered cycles.
- Realign: ch0 D=4, ch1 D=6 drifted out of phase, sync_restart -> both clk_en=1 on the next edge, then periods 4 and 6 from that edge.
